sum_window_acc: RTL

- Downstream consumer of the five-input 1-bit adder stage, whose 3-bit sum is 0..5.
- Accepts one sum per valid/ready beat and accumulates WINDOW beats into a window total.
- Presents the total with a threshold flag on a valid/ready output port.
- Feeds monitoring and statistics logic that needs per-window popcount totals rather than per-cycle sums.

---
 rtl/sum_pkg.sv | 26 ++
 rtl/sum_window_acc.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sum_pkg.sv
// Shared types and helpers for the five-input adder sum consumers.
// Sums are 3-bit and legal only in 0..5.
package sum_pkg;

  localparam int         SUM_W   = 3;
  localparam logic [2:0] MAX_SUM = 3'd5;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  typedef struct packed {
    logic [SUM_W-1:0] val;
    logic             illegal;
  } clamp_t;

  // Out-of-range codes (6, 7) saturate to MAX_SUM and are flagged.
  function automatic clamp_t clamp_sum(input logic [SUM_W-1:0] s);
    clamp_t r;
    r.illegal = (s > MAX_SUM);
    r.val     = r.illegal ? MAX_SUM : s;
    return r;
  endfunction

endpackage

// File: rtl/sum_window_acc.sv
// Accumulates WINDOW accepted sums into a total with a threshold flag; result one cycle after the closing beat.
// Input stalls only while a result is held and out_ready is low (in_ready = out_ready in HOLD).
module sum_window_acc
  import sum_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int ACC_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_over,
  output logic             err
);

  localparam int CNT_W = $clog2(WINDOW);

  if (WINDOW < 2 || WINDOW > 64) begin : g_bad_window
    $error("sum_window_acc: WINDOW must be in 2..64");
  end
  if (ACC_W < $clog2(5 * WINDOW + 1)) begin : g_bad_acc_w
    $error("sum_window_acc: ACC_W too narrow for 5*WINDOW");
  end

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_total_q, out_total_d;
  logic             out_over_q, out_over_d;
  logic             err_q, err_d;

  clamp_t           cl;
  logic             beat;
  logic [ACC_W-1:0] sum_next;

  // Output logic: the only combinational path is out_ready -> in_ready while holding.
  assign in_ready  = (state_q == ACCUM) | out_ready;
  assign out_valid = out_valid_q;
  assign out_total = out_total_q;
  assign out_over  = out_over_q;
  assign err       = err_q;

  assign cl       = clamp_sum(in_sum);
  assign beat     = in_valid & in_ready;
  assign sum_next = acc_q + ACC_W'(cl.val);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_total_d = out_total_q;
    out_over_d  = out_over_q;
    err_d       = err_q;

    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_total_d = '0;
      out_over_d  = 1'b0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (beat) begin
            err_d = err_q | cl.illegal;
            if (cnt_q == CNT_W'(WINDOW - 1)) begin
              out_total_d = sum_next;
              out_over_d  = (sum_next >= thresh);
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              state_d     = HOLD;
            end else begin
              acc_d = sum_next;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
            // WINDOW >= 2, so a beat taken here can never close a window.
            if (beat) begin
              acc_d = ACC_W'(cl.val);
              cnt_d = CNT_W'(1);
              err_d = err_q | cl.illegal;
            end
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_total_q <= '0;
      out_over_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_total_q <= out_total_d;
      out_over_q  <= out_over_d;
      err_q       <= err_d;
    end
  end

endmodule
